mcp_controller: RTL

Multi-cycle control unit for the RV32I core. It replaces the purely combinational single-cycle decoder with a state machine that sequences FETCH, DECODE, EXECUTE, MEM and WRITEBACK over a shared variable-latency memory. It adds a valid/ready memory handshake, a memory-wait timeout, illegal-instruction detection with a sticky trap, and a retired-instruction counter. It sits between the instruction register, register file and memory port of the multi-cycle datapath.

---
 rtl/mcp_pkg.sv | 80 ++++++++
 rtl/mcp_if.sv | 9 +
 rtl/mcp_decoder.sv | 65 ++++++
 rtl/mcp_controller.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mcp_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package mcp_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CLS_R,
    CLS_I_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC
  } cls_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SLL    = 4'b0101;
  localparam logic [3:0] ALU_SRL    = 4'b0110;
  localparam logic [3:0] ALU_SRA    = 4'b0111;
  localparam logic [3:0] ALU_SLT    = 4'b1000;
  localparam logic [3:0] ALU_SLTU   = 4'b1001;
  localparam logic [3:0] ALU_OR     = 4'b1010;
  localparam logic [3:0] ALU_AND    = 4'b1011;
  localparam logic [3:0] ALU_PASS_B = 4'b1100;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // funct3 -> ALU op; sub_alt selects SUB at 000, sra_alt selects SRA at 101
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3,
                                                 input logic       sub_alt,
                                                 input logic       sra_alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = sub_alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = sra_alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mcp_if.sv
// Memory request handshake between the control unit and the shared memory port.
interface mcp_if;
  logic MEM_REQ_o;
  logic WE_o;
  logic mem_ready_i;

  modport master (output MEM_REQ_o, output WE_o, input mem_ready_i);
  modport slave  (input MEM_REQ_o, input WE_o, output mem_ready_i);
endinterface

// File: rtl/mcp_decoder.sv
// Combinational instruction decode: class, ALU op, immediate format, illegal flag.
module mcp_decoder
  import mcp_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output cls_e       cls_o,
  output logic [3:0] alu_op_o,
  output logic [2:0] imm_sel_o,
  output logic       illegal_o
);

  // Class and per-class controls from opcode/funct fields
  always_comb begin
    cls_o     = CLS_R;
    alu_op_o  = ALU_ADD;
    imm_sel_o = IMM_I;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_OP: begin
        cls_o     = CLS_R;
        alu_op_o  = alu_from_funct3(funct3_i, funct7_i[5], funct7_i[5]);
        illegal_o = !((funct7_i == 7'h00) ||
                      ((funct7_i == 7'h20) && ((funct3_i == 3'b000) || (funct3_i == 3'b101))));
      end
      OPC_OP_IMM: begin
        cls_o    = CLS_I_ALU;
        alu_op_o = alu_from_funct3(funct3_i, 1'b0, funct7_i[5]);
      end
      OPC_LOAD: begin
        cls_o     = CLS_LOAD;
        illegal_o = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
      end
      OPC_STORE: begin
        cls_o     = CLS_STORE;
        imm_sel_o = IMM_S;
        illegal_o = (funct3_i > 3'b010);
      end
      OPC_BRANCH: begin
        cls_o     = CLS_BRANCH;
        imm_sel_o = IMM_B;
        illegal_o = (funct3_i == 3'b010) || (funct3_i == 3'b011);
      end
      OPC_JAL: begin
        cls_o     = CLS_JAL;
        imm_sel_o = IMM_J;
      end
      OPC_JALR: begin
        cls_o = CLS_JALR;
      end
      OPC_LUI: begin
        cls_o     = CLS_LUI;
        imm_sel_o = IMM_U;
        alu_op_o  = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        cls_o     = CLS_AUIPC;
        imm_sel_o = IMM_U;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mcp_controller.sv
// Multi-cycle control unit: FSM, memory-wait timeout, branch compare, retire counter.
module mcp_controller
  import mcp_pkg::*;
#(
  parameter int unsigned X_LEN       = 32,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      instr_i,
  input  logic [X_LEN-1:0] rs1_data_i,
  input  logic [X_LEN-1:0] rs2_data_i,
  mcp_if.master            mem,
  output logic             IR_WE_o,
  output logic             PC_WE_o,
  output logic             PC_SEL_o,
  output logic [2:0]       IMM_SEL_o,
  output logic             REG_WRITE_o,
  output logic             A_SEL_o,
  output logic             B_SEL_o,
  output logic [3:0]       ALU_OP_o,
  output logic [1:0]       WB_SEL_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o,
  output logic [CNT_W-1:0] instret_o,
  output logic [2:0]       state_o
);

  // Counter only has to hold 0..TIMEOUT_CYC-1; the miss at TIMEOUT_CYC-1 traps
  localparam int unsigned WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  state_e            state_q;
  logic [1:0]        cause_q;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  instret_q;

  cls_e       cls;
  logic [3:0] alu_op;
  logic [2:0] imm_sel;
  logic       illegal;
  logic       taken;
  logic       wait_expired;
  logic       unused_instr;

  assign unused_instr = ^{instr_i[24:15], instr_i[11:7]};

  mcp_decoder u_decoder (
    .opcode_i  (instr_i[6:0]),
    .funct3_i  (instr_i[14:12]),
    .funct7_i  (instr_i[31:25]),
    .cls_o     (cls),
    .alu_op_o  (alu_op),
    .imm_sel_o (imm_sel),
    .illegal_o (illegal)
  );

  // Branch condition from funct3: signed for BLT/BGE, unsigned for BLTU/BGEU
  always_comb begin
    taken = 1'b0;
    case (instr_i[14:12])
      3'b000:  taken = (rs1_data_i == rs2_data_i);
      3'b001:  taken = (rs1_data_i != rs2_data_i);
      3'b100:  taken = ($signed(rs1_data_i) <  $signed(rs2_data_i));
      3'b101:  taken = ($signed(rs1_data_i) >= $signed(rs2_data_i));
      3'b110:  taken = (rs1_data_i <  rs2_data_i);
      3'b111:  taken = (rs1_data_i >= rs2_data_i);
      default: taken = 1'b0;
    endcase
  end

  // This miss would bring the wait count up to the limit; a ready in this cycle wins
  assign wait_expired = !mem.mem_ready_i && (wait_q == WAIT_LAST);

  // State sequencing, trap cause capture and memory-wait counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cause_q <= CAUSE_NONE;
      wait_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_FETCH;
        S_FETCH, S_MEM: begin
          if (mem.mem_ready_i) begin
            wait_q <= '0;
            if (state_q == S_FETCH)      state_q <= S_DECODE;
            else if (cls == CLS_STORE)   state_q <= S_FETCH;
            else                         state_q <= S_WB;
          end else if (wait_expired) begin
            state_q <= S_TRAP;
            cause_q <= CAUSE_TIMEOUT;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          if (illegal) begin
            state_q <= S_TRAP;
            cause_q <= CAUSE_ILLEGAL;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cls == CLS_BRANCH)                            state_q <= S_FETCH;
          else if ((cls == CLS_LOAD) || (cls == CLS_STORE)) state_q <= S_MEM;
          else                                              state_q <= S_WB;
        end
        S_WB:    state_q <= S_FETCH;
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Control outputs; ALU controls stay valid from EXEC through MEM/WB
  always_comb begin
    mem.MEM_REQ_o = 1'b0;
    mem.WE_o      = 1'b0;
    IR_WE_o       = 1'b0;
    PC_WE_o       = 1'b0;
    PC_SEL_o      = 1'b0;
    IMM_SEL_o     = IMM_I;
    REG_WRITE_o   = 1'b0;
    A_SEL_o       = 1'b0;
    B_SEL_o       = 1'b0;
    ALU_OP_o      = ALU_ADD;
    WB_SEL_o      = WB_ALU;
    if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
      A_SEL_o   = (cls == CLS_BRANCH) || (cls == CLS_JAL) || (cls == CLS_AUIPC);
      B_SEL_o   = (cls != CLS_R);
      IMM_SEL_o = imm_sel;
      ALU_OP_o  = alu_op;
    end
    case (state_q)
      S_FETCH: begin
        mem.MEM_REQ_o = 1'b1;
        A_SEL_o       = 1'b1;
        IR_WE_o       = mem.mem_ready_i;
      end
      S_EXEC: begin
        if (cls == CLS_BRANCH) begin
          PC_WE_o  = 1'b1;
          PC_SEL_o = taken;
        end
      end
      S_MEM: begin
        mem.MEM_REQ_o = 1'b1;
        mem.WE_o      = (cls == CLS_STORE);
        PC_WE_o       = (cls == CLS_STORE) && mem.mem_ready_i;
      end
      S_WB: begin
        REG_WRITE_o = 1'b1;
        PC_WE_o     = 1'b1;
        if (cls == CLS_LOAD) begin
          WB_SEL_o = WB_MEM;
        end else if ((cls == CLS_JAL) || (cls == CLS_JALR)) begin
          WB_SEL_o = WB_PC4;
          PC_SEL_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Retired-instruction counter: one per PC update, wraps naturally
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      instret_q <= '0;
    else if (PC_WE_o) instret_q <= instret_q + CNT_W'(1);
  end

  assign instret_o    = instret_q;
  assign trap_o       = (state_q == S_TRAP);
  assign trap_cause_o = cause_q;
  assign state_o      = state_q;

endmodule
